comm_fpga_epp_ext: RTL and testbench
====================================

Name: comm_fpga_epp_ext

Overview:
Parametrised next-generation EPP-to-channel bridge. Converts asynchronous host EPP cycles into the clocked h2f/f2h valid/ready channel pipes, using a configurable synchroniser depth and channel address width. Adds capabilities the first-generation bridge lacks:
- address readback
- a sticky error/status flag
- a per-transfer channel-stall timeout that completes the host cycle instead of hanging the parallel port

Sits between the top-level EPP pins and the application channel mux.

Parameters:
ADDR_WIDTH, 7, channel address width (1..7); chanAddr_out = ADDR_WIDTH bits.
SYNC_STAGES, 2, flops in each strobe/write synchroniser chain (2..4).
TIMEOUT_WIDTH, 10, stall counter width; timeout fires at 2^TIMEOUT_WIDTH-1 cycles stalled in an EXEC state.

Ports:
clk_in  in  1  sole clock, asynchronous to EPP signals
resetn_in  in  1  asynchronous active-low reset
eppData_io  inout  8  EPP bidirectional data
eppAddrStb_in  in  1  active-low async address strobe
eppDataStb_in  in  1  active-low async data strobe
eppWrite_in  in  1  1=read, 0=write
eppWait_out  out  1  EPP wait handshake
chanAddr_out  out  ADDR_WIDTH  selected channel
h2fData_out  out  8  host-to-FPGA data
h2fValid_out  out  1  h2f byte presented this cycle
h2fReady_in  in  1  channel accepts h2f byte
f2hData_in  in  8  FPGA-to-host data
f2hValid_in  in  1  channel has f2h byte
f2hReady_out  out  1  f2h byte consumed this cycle
timeout_out  out  1  one-cycle pulse when a timeout fires
errFlag_out  out  1  sticky timeout flag

Behaviour:
- Reset (resetn_in low, async):
  - state=IDLE; chanAddr=0; eppWait=0; eppData reg=0x00; errFlag=0; stall counter=0.
  - All synchroniser stages=1 (strobes inactive, read direction).
  - h2fValid_out, f2hReady_out and timeout_out are 0.
- Synchronisers: SYNC_STAGES flops; FSM uses the last stage only, so strobe-to-FSM latency = SYNC_STAGES cycles.
- Bus drive: eppData_io = eppData reg when raw eppWrite_in=1, else Z.
- States:
  - IDLE: eppWait=0.
    - AddrStb low and write -> chanAddr=eppData_io[ADDR_WIDTH-1:0]; eppWait=1; ADDR_WRITE_WAIT.
    - AddrStb low and read -> eppData reg={errFlag, zero pad, chanAddr}; errFlag cleared; eppWait=1; ADDR_READ_WAIT.
    - Else DataStb low -> DATA_WRITE_EXEC or DATA_READ_EXEC per write_sync; stall counter cleared.
    - AddrStb has priority when both strobes are low.
  - ADDR_WRITE_WAIT / ADDR_READ_WAIT: AddrStb_sync high -> eppWait=0, IDLE.
  - DATA_WRITE_EXEC: h2fData_out=eppData_io, h2fValid_out=1.
    - h2fReady_in=1 -> eppWait=1, DATA_WRITE_WAIT.
    - Else counter++; at terminal count -> byte dropped, errFlag=1, timeout_out pulse, eppWait=1, DATA_WRITE_WAIT.
  - DATA_READ_EXEC: f2hReady_out=1, eppData reg=f2hData_in.
    - f2hValid_in=1 -> eppWait=1, DATA_READ_WAIT.
    - Timeout -> eppData reg=0xFF, errFlag=1, timeout_out pulse, eppWait=1, DATA_READ_WAIT; no byte consumed, so f2hReady_out is 0 in the timeout cycle.
  - DATA_WRITE_WAIT / DATA_READ_WAIT: DataStb_sync high -> eppWait=0, IDLE.
- Ready and timeout in the same cycle: the ready/valid handshake wins; no error is raised.
- Outside the EXEC states, h2fData_out=0x00, h2fValid_out=0 and f2hReady_out=0.
- Any unused state encoding returns to IDLE with eppWait=0.
- Reset asserted mid-cycle: immediate return to reset values; the host sees wait drop.

Optional Feature:
COMM_EPP_AUTOINC_EN:
- Defined:
  - On address write, eppData_io[7] latches an autoinc bit.
  - When autoinc=1, chanAddr increments (mod 2^ADDR_WIDTH) on the cycle of each successful data handshake; a timeout does not increment.
  - The autoinc bit is reset to 0 and reported in address readback bit 6 when ADDR_WIDTH<7.
- Undefined: bit 7 of an address write is ignored and chanAddr changes only on address writes.

Test Plan:
- Address write 0x25, then address read -> eppWait rises SYNC_STAGES+1 cycles after AddrStb falls; chanAddr_out=0x25; readback=0x25.
- Data write 0xA5 with h2fReady_in=1 -> exactly one cycle with h2fValid_out=1 and h2fData_out=0xA5; eppWait high until DataStb rises.
- Data read with f2hValid_in held 0 for 2^TIMEOUT_WIDTH cycles -> timeout_out pulses once; host reads 0xFF; errFlag_out=1; next address read returns bit7=1, after which errFlag_out=0.
- Data write with h2fReady_in going high on the terminal-count cycle -> byte accepted; errFlag_out stays 0.
- Reset pulsed low during DATA_WRITE_WAIT -> eppWait_out=0 and chanAddr_out=0 asynchronously; the next cycle completes normally.
- COMM_EPP_AUTOINC_EN, ADDR_WIDTH=3: address write 0x87 then two data writes -> chanAddr_out goes 7, 0, 1.

Source files
------------

// File: rtl/comm_fpga_epp_ext.sv
// EPP-to-channel bridge with address readback, sticky timeout flag and per-transfer stall timeout.
// Optional build macro COMM_EPP_AUTOINC_EN: address-write bit 7 enables channel auto-increment.
module comm_fpga_epp_ext #(
    parameter int ADDR_WIDTH    = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT_WIDTH = 10
) (
    input  logic                  clk_in,
    input  logic                  resetn_in,
    inout  wire  [7:0]            eppData_io,
    input  logic                  eppAddrStb_in,
    input  logic                  eppDataStb_in,
    input  logic                  eppWrite_in,
    output logic                  eppWait_out,
    output logic [ADDR_WIDTH-1:0] chanAddr_out,
    output logic [7:0]            h2fData_out,
    output logic                  h2fValid_out,
    input  logic                  h2fReady_in,
    input  logic [7:0]            f2hData_in,
    input  logic                  f2hValid_in,
    output logic                  f2hReady_out,
    output logic                  timeout_out,
    output logic                  errFlag_out,
    output logic [2:0]            dbgState_out
);

    // Channel handshake: a byte moves on h2f when h2fValid_out && h2fReady_in,
    // and on f2h when f2hValid_in && f2hReady_out, both sampled at the rising clk_in edge.

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        ADDR_WRITE_WAIT = 3'd1,
        ADDR_READ_WAIT  = 3'd2,
        DATA_WRITE_EXEC = 3'd3,
        DATA_WRITE_WAIT = 3'd4,
        DATA_READ_EXEC  = 3'd5,
        DATA_READ_WAIT  = 3'd6
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] STALL_MAX = '1;

    state_t                   state, stateNext;
    logic [ADDR_WIDTH-1:0]    chanAddr, chanAddrNext;
    logic                     eppWait, eppWaitNext;
    logic [7:0]               eppDataReg, eppDataNext;
    logic                     errFlag, errFlagNext;
    logic [TIMEOUT_WIDTH-1:0] stallCount, stallNext;
    logic [7:0]               readback;
    logic                     xferDone;
    logic                     addrWriteNow;
    logic                     autoInc;

    logic [SYNC_STAGES-1:0]   addrStbSync, dataStbSync, writeSync;
    logic                     addrStbLast, dataStbLast, writeLast;

    // Reset to 1 so the FSM sees idle strobes and read direction until the host acts.
    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            addrStbSync <= '1;
            dataStbSync <= '1;
            writeSync   <= '1;
        end else begin
            addrStbSync <= {addrStbSync[SYNC_STAGES-2:0], eppAddrStb_in};
            dataStbSync <= {dataStbSync[SYNC_STAGES-2:0], eppDataStb_in};
            writeSync   <= {writeSync[SYNC_STAGES-2:0], eppWrite_in};
        end
    end

    assign addrStbLast = addrStbSync[SYNC_STAGES-1];
    assign dataStbLast = dataStbSync[SYNC_STAGES-1];
    assign writeLast   = writeSync[SYNC_STAGES-1];

`ifdef COMM_EPP_AUTOINC_EN
    logic autoIncNext;

    always_comb begin
        autoIncNext = autoInc;
        if (addrWriteNow) autoIncNext = eppData_io[7];
    end

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) autoInc <= 1'b0;
        else            autoInc <= autoIncNext;
    end
`else
    assign autoInc = 1'b0;
`endif

    always_comb begin
        readback = '0;
        readback[ADDR_WIDTH-1:0] = chanAddr;
`ifdef COMM_EPP_AUTOINC_EN
        if (ADDR_WIDTH < 7) readback[6] = autoInc;
`endif
        readback[7] = errFlag;
    end

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state      <= IDLE;
            chanAddr   <= '0;
            eppWait    <= 1'b0;
            eppDataReg <= 8'h00;
            errFlag    <= 1'b0;
            stallCount <= '0;
        end else begin
            state      <= stateNext;
            chanAddr   <= chanAddrNext;
            eppWait    <= eppWaitNext;
            eppDataReg <= eppDataNext;
            errFlag    <= errFlagNext;
            stallCount <= stallNext;
        end
    end

    always_comb begin
        stateNext    = state;
        chanAddrNext = chanAddr;
        eppWaitNext  = eppWait;
        eppDataNext  = eppDataReg;
        errFlagNext  = errFlag;
        stallNext    = stallCount;
        h2fData_out  = 8'h00;
        h2fValid_out = 1'b0;
        f2hReady_out = 1'b0;
        timeout_out  = 1'b0;
        xferDone     = 1'b0;
        addrWriteNow = 1'b0;

        case (state)
            IDLE: begin
                eppWaitNext = 1'b0;
                if (!addrStbLast) begin
                    eppWaitNext = 1'b1;
                    if (!writeLast) begin
                        addrWriteNow = 1'b1;
                        chanAddrNext = eppData_io[ADDR_WIDTH-1:0];
                        stateNext    = ADDR_WRITE_WAIT;
                    end else begin
                        eppDataNext = readback;
                        errFlagNext = 1'b0;
                        stateNext   = ADDR_READ_WAIT;
                    end
                end else if (!dataStbLast) begin
                    stallNext = '0;
                    stateNext = writeLast ? DATA_READ_EXEC : DATA_WRITE_EXEC;
                end
            end

            ADDR_WRITE_WAIT, ADDR_READ_WAIT: begin
                if (addrStbLast) begin
                    eppWaitNext = 1'b0;
                    stateNext   = IDLE;
                end
            end

            DATA_WRITE_EXEC: begin
                h2fData_out  = eppData_io;
                h2fValid_out = 1'b1;
                if (h2fReady_in) begin
                    xferDone    = 1'b1;
                    eppWaitNext = 1'b1;
                    stateNext   = DATA_WRITE_WAIT;
                end else if (stallCount == STALL_MAX) begin
                    errFlagNext = 1'b1;
                    timeout_out = 1'b1;
                    eppWaitNext = 1'b1;
                    stateNext   = DATA_WRITE_WAIT;
                end else begin
                    stallNext = stallCount + TIMEOUT_WIDTH'(1);
                end
            end

            DATA_READ_EXEC: begin
                f2hReady_out = 1'b1;
                eppDataNext  = f2hData_in;
                if (f2hValid_in) begin
                    xferDone    = 1'b1;
                    eppWaitNext = 1'b1;
                    stateNext   = DATA_READ_WAIT;
                end else if (stallCount == STALL_MAX) begin
                    // Nothing is consumed on a timeout; the host reads 0xFF instead.
                    f2hReady_out = 1'b0;
                    eppDataNext  = 8'hFF;
                    errFlagNext  = 1'b1;
                    timeout_out  = 1'b1;
                    eppWaitNext  = 1'b1;
                    stateNext    = DATA_READ_WAIT;
                end else begin
                    stallNext = stallCount + TIMEOUT_WIDTH'(1);
                end
            end

            DATA_WRITE_WAIT, DATA_READ_WAIT: begin
                if (dataStbLast) begin
                    eppWaitNext = 1'b0;
                    stateNext   = IDLE;
                end
            end

            default: begin
                eppWaitNext = 1'b0;
                stateNext   = IDLE;
            end
        endcase

        if (xferDone && autoInc) chanAddrNext = chanAddr + ADDR_WIDTH'(1);
    end

    assign eppData_io   = eppWrite_in ? eppDataReg : 8'bzzzz_zzzz;
    assign eppWait_out  = eppWait;
    assign chanAddr_out = chanAddr;
    assign errFlag_out  = errFlag;
    assign dbgState_out = state;

endmodule

// File: tb/tb_comm_fpga_epp_ext.sv
// Directed bench for comm_fpga_epp_ext: host EPP tasks, channel-side scoreboard monitor.
module tb_comm_fpga_epp_ext;

    localparam int AW    = 7;
    localparam int SYNC  = 2;
    localparam int TW    = 10;
    localparam int LIMIT = 3000;

    logic          clk_in = 1'b0;
    logic          resetn_in;
    wire  [7:0]    eppData;
    logic          hostDrive;
    logic [7:0]    hostData;
    logic          eppAddrStb_in, eppDataStb_in, eppWrite_in;
    logic          eppWait_out;
    logic [AW-1:0] chanAddr_out;
    logic [7:0]    h2fData_out;
    logic          h2fValid_out, h2fReady_in;
    logic [7:0]    f2hData_in;
    logic          f2hValid_in, f2hReady_out;
    logic          timeout_out, errFlag_out;
    logic [2:0]    dbgState_out;

    assign eppData = hostDrive ? hostData : 8'bzzzz_zzzz;

    // clock / reset
    always #5 clk_in = ~clk_in;

    comm_fpga_epp_ext #(.ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .TIMEOUT_WIDTH(TW)) dut (
        .clk_in(clk_in), .resetn_in(resetn_in), .eppData_io(eppData),
        .eppAddrStb_in(eppAddrStb_in), .eppDataStb_in(eppDataStb_in), .eppWrite_in(eppWrite_in),
        .eppWait_out(eppWait_out), .chanAddr_out(chanAddr_out),
        .h2fData_out(h2fData_out), .h2fValid_out(h2fValid_out), .h2fReady_in(h2fReady_in),
        .f2hData_in(f2hData_in), .f2hValid_in(f2hValid_in), .f2hReady_out(f2hReady_out),
        .timeout_out(timeout_out), .errFlag_out(errFlag_out), .dbgState_out(dbgState_out)
    );

    int nChecks = 0;
    int nFail   = 0;
    logic [7:0] h2fExpQ[$];
    logic [7:0] rdExpQ[$];
    int h2fValidCnt, h2fHsCnt, f2hReadyCnt, f2hHsCnt, timeoutCnt;
    logic prevWait = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearCounts();
        h2fValidCnt = 0; h2fHsCnt = 0; f2hReadyCnt = 0; f2hHsCnt = 0; timeoutCnt = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic waitLevel(input logic level, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (eppWait_out !== level && cycles < LIMIT);
        if (eppWait_out !== level) begin
            nChecks++;
            nFail++;
            $display("FAIL wait_bound: eppWait stuck at %0b, expected %0b", eppWait_out, level);
        end
    endtask

    // driver tasks
    task automatic hostAddrWrite(input logic [7:0] a);
        int c;
        hostDrive = 1'b1; hostData = a; eppWrite_in = 1'b0; eppAddrStb_in = 1'b0;
        waitLevel(1'b1, c);
        eppAddrStb_in = 1'b1;
        waitLevel(1'b0, c);
        hostDrive = 1'b0; eppWrite_in = 1'b1;
    endtask

    task automatic hostAddrRead(input logic [7:0] exp);
        int c;
        rdExpQ.push_back(exp);
        eppWrite_in = 1'b1; eppAddrStb_in = 1'b0;
        waitLevel(1'b1, c);
        eppAddrStb_in = 1'b1;
        waitLevel(1'b0, c);
    endtask

    task automatic hostDataWrite(input logic [7:0] d);
        int c;
        h2fExpQ.push_back(d);
        hostDrive = 1'b1; hostData = d; eppWrite_in = 1'b0; eppDataStb_in = 1'b0;
        waitLevel(1'b1, c);
        repeat (2) tick();
        check("wait_hold", eppWait_out, 1'b1);
        eppDataStb_in = 1'b1;
        waitLevel(1'b0, c);
        hostDrive = 1'b0; eppWrite_in = 1'b1;
    endtask

    task automatic hostDataRead(input logic [7:0] exp);
        int c;
        rdExpQ.push_back(exp);
        eppWrite_in = 1'b1; eppDataStb_in = 1'b0;
        waitLevel(1'b1, c);
        eppDataStb_in = 1'b1;
        waitLevel(1'b0, c);
    endtask

    // scoreboard monitor
    always @(negedge clk_in) begin
        logic [7:0] e;
        if (h2fValid_out) h2fValidCnt++;
        if (h2fValid_out && h2fReady_in) begin
            h2fHsCnt++;
            if (h2fExpQ.size() == 0) begin
                nChecks++; nFail++;
                $display("FAIL h2f_unexpected: got 0x%0h, expected no byte", h2fData_out);
            end else begin
                e = h2fExpQ.pop_front();
                check("h2f_data", h2fData_out, e);
            end
        end
        if (f2hReady_out) f2hReadyCnt++;
        if (f2hReady_out && f2hValid_in) f2hHsCnt++;
        if (timeout_out) timeoutCnt++;
        if (eppWait_out && !prevWait && eppWrite_in) begin
            if (rdExpQ.size() == 0) begin
                nChecks++; nFail++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no read", eppData);
            end else begin
                e = rdExpQ.pop_front();
                check("host_read", eppData, e);
            end
        end
        prevWait = eppWait_out;
    end

    initial begin
        int c;
        logic [AW-1:0] a1, a2;
        resetn_in = 1'b0; hostDrive = 1'b0; hostData = 8'h00;
        eppAddrStb_in = 1'b1; eppDataStb_in = 1'b1; eppWrite_in = 1'b1;
        h2fReady_in = 1'b0; f2hValid_in = 1'b0; f2hData_in = 8'h00;
        clearCounts();
        repeat (3) tick();

        check("rst_wait", eppWait_out, 1'b0);
        check("rst_chanAddr", chanAddr_out, 0);
        check("rst_h2fValid", h2fValid_out, 1'b0);
        check("rst_f2hReady", f2hReady_out, 1'b0);
        check("rst_timeout", timeout_out, 1'b0);
        check("rst_errFlag", errFlag_out, 1'b0);
        check("rst_bus", eppData, 8'h00);
        check("rst_state", dbgState_out, 3'd0);
        resetn_in = 1'b1;
        repeat (2) tick();

        // address write 0x25 with strobe-to-wait latency
        hostDrive = 1'b1; hostData = 8'h25; eppWrite_in = 1'b0; eppAddrStb_in = 1'b0;
        waitLevel(1'b1, c);
        check("addr_wait_latency", c, SYNC + 1);
        check("addr_write_chan", chanAddr_out, 7'h25);
        eppAddrStb_in = 1'b1;
        waitLevel(1'b0, c);
        hostDrive = 1'b0; eppWrite_in = 1'b1;
        hostAddrRead(8'h25);
        check("errFlag_clean", errFlag_out, 1'b0);

        // data write accepted immediately
        clearCounts(); h2fReady_in = 1'b1;
        hostDataWrite(8'hA5);
        h2fReady_in = 1'b0;
        check("wr_valid_cycles", h2fValidCnt, 1);
        check("wr_handshakes", h2fHsCnt, 1);
        check("idle_h2fData", h2fData_out, 8'h00);

        // data read with byte available
        clearCounts(); f2hValid_in = 1'b1; f2hData_in = 8'h3C;
        hostDataRead(8'h3C);
        f2hValid_in = 1'b0;
        check("rd_handshakes", f2hHsCnt, 1);
        check("rd_no_timeout", timeoutCnt, 0);

        // data read that stalls into the timeout
        clearCounts(); f2hData_in = 8'h5A;
        hostDataRead(8'hFF);
        check("to_pulses", timeoutCnt, 1);
        check("to_no_consume", f2hHsCnt, 0);
        check("to_ready_cycles", f2hReadyCnt, (1 << TW) - 1);
        check("to_errFlag_set", errFlag_out, 1'b1);
        hostAddrRead(8'hA5);
        check("to_errFlag_cleared", errFlag_out, 1'b0);

        // handshake on the terminal-count cycle beats the timeout
        clearCounts(); h2fReady_in = 1'b0;
        h2fExpQ.push_back(8'h5E);
        hostDrive = 1'b1; hostData = 8'h5E; eppWrite_in = 1'b0; eppDataStb_in = 1'b0;
        c = 0;
        do begin tick(); c++; end while (!h2fValid_out && c < LIMIT);
        check("tc_valid_seen", h2fValid_out, 1'b1);
        repeat ((1 << TW) - 1) tick();
        h2fReady_in = 1'b1;
        waitLevel(1'b1, c);
        h2fReady_in = 1'b0;
        eppDataStb_in = 1'b1;
        waitLevel(1'b0, c);
        hostDrive = 1'b0; eppWrite_in = 1'b1;
        check("tc_no_timeout", timeoutCnt, 0);
        check("tc_errFlag", errFlag_out, 1'b0);
        check("tc_handshakes", h2fHsCnt, 1);
        check("tc_valid_cycles", h2fValidCnt, 1 << TW);

        // address bit 7 handling followed by two data writes
`ifdef COMM_EPP_AUTOINC_EN
        a1 = 7'h08; a2 = 7'h09;
`else
        a1 = 7'h07; a2 = 7'h07;
`endif
        hostAddrWrite(8'h87);
        check("b7_chan", chanAddr_out, 7'h07);
        h2fReady_in = 1'b1;
        hostDataWrite(8'h11);
        check("b7_chan_1", chanAddr_out, a1);
        hostDataWrite(8'h22);
        check("b7_chan_2", chanAddr_out, a2);
        h2fReady_in = 1'b0;
        hostAddrRead({1'b0, a2});

        // reset pulsed during DATA_WRITE_WAIT
        hostAddrWrite(8'h33);
        h2fReady_in = 1'b1;
        h2fExpQ.push_back(8'h44);
        hostDrive = 1'b1; hostData = 8'h44; eppWrite_in = 1'b0; eppDataStb_in = 1'b0;
        waitLevel(1'b1, c);
        check("mid_state", dbgState_out, 3'd4);
        resetn_in = 1'b0;
        #1;
        check("mid_rst_wait", eppWait_out, 1'b0);
        check("mid_rst_chan", chanAddr_out, 0);
        eppDataStb_in = 1'b1; hostDrive = 1'b0; eppWrite_in = 1'b1;
        tick();
        resetn_in = 1'b1;
        repeat (2) tick();
        clearCounts();
        hostAddrWrite(8'h12);
        check("post_rst_chan", chanAddr_out, 7'h12);
        hostDataWrite(8'h66);
        h2fReady_in = 1'b0;
        check("post_rst_hs", h2fHsCnt, 1);
        hostAddrRead(8'h12);

        repeat (3) tick();
        check("h2f_queue_drained", h2fExpQ.size(), 0);
        check("rd_queue_drained", rdExpQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
